// File: rtl/amm_arb_pkg.sv
// amm_arb_pkg
//   Shared types for the two-requester Avalon-MM master arbiter.
//   arb_state_t : arbiter FSM state (ARB = free arbitration, HOLD = grant
//                 frozen while the slave stalls).
//   rq_id_t     : requester identifier stored per outstanding read.
//   NUM_RQ      : number of requesters sharing the master port.
package amm_arb_pkg;

  localparam int NUM_RQ = 2;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef logic rq_id_t;

endpackage

// File: rtl/rd_id_fifo.sv
// rd_id_fifo
//   Synchronous FIFO holding the requester ID of every outstanding read,
//   oldest at the head. Pointers wrap modulo DEPTH, so DEPTH need not be a
//   power of two.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push, push_id  : enqueue push_id (ignored when full)
//   pop            : dequeue the head (ignored when empty)
//   full, empty    : occupancy flags
//   head           : ID at the head, valid when !empty
//   count          : number of stored IDs, 0..DEPTH
module rd_id_fifo
  import amm_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  rq_id_t                       push_id,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output rq_id_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rq_id_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_eff, pop_eff;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop_eff) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      count_q <= count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/amm_master_arbiter.sv
// amm_master_arbiter
//   Shares one Avalon-MM master port between two requesters (0 = PCA
//   projection engine, 1 = face-distance engine). Commands are granted
//   round-robin; the grant is frozen while the slave asserts waitrequest.
//   Outstanding read IDs are queued so each readdatavalid is routed back to
//   the requester that issued the read.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rq_address/writedata  : per-requester command payload
//   rq_read/rq_write      : per-requester strobes (write wins if both set)
//   rq_waitrequest        : low only in the cycle that requester's command
//                           is accepted by the slave
//   rq_readdata           : master_readdata broadcast to both requesters
//   rq_readdatavalid      : one-hot routed read-data-valid
//   master_*              : shared Avalon-MM master port
//   pending_count         : outstanding reads
//   err_unexpected_rdv    : sticky, readdatavalid seen with no read pending
//   arb_state             : current FSM state for observation
//
// Handshake: a command transfers in the cycle its strobe is high and
// master_waitrequest is low; that same cycle rq_waitrequest[sel] is low.
// While master_waitrequest is high the forwarded command does not change.
module amm_master_arbiter
  import amm_arb_pkg::*;
#(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32,
  parameter int MAX_PENDING  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_RQ-1:0][ADDRESSWIDTH-1:0] rq_address,
  input  logic [NUM_RQ-1:0][DATAWIDTH-1:0]    rq_writedata,
  input  logic [NUM_RQ-1:0]                   rq_read,
  input  logic [NUM_RQ-1:0]                   rq_write,
  output logic [NUM_RQ-1:0]                   rq_waitrequest,
  output logic [DATAWIDTH-1:0]                rq_readdata,
  output logic [NUM_RQ-1:0]                   rq_readdatavalid,
  output logic [ADDRESSWIDTH-1:0]             master_address,
  output logic [DATAWIDTH-1:0]                master_writedata,
  output logic                                master_read,
  output logic                                master_write,
  input  logic [DATAWIDTH-1:0]                master_readdata,
  input  logic                                master_readdatavalid,
  input  logic                                master_waitrequest,
  output logic [$clog2(MAX_PENDING+1)-1:0]    pending_count,
  output logic                                err_unexpected_rdv,
  output arb_state_t                          arb_state
);

  arb_state_t  state_q, state_d;
  rq_id_t      owner_q, owner_d;
  rq_id_t      last_q, last_d;
  logic        err_q, err_d;

  logic        fifo_full, fifo_empty;
  rq_id_t      fifo_head;
  logic [NUM_RQ-1:0] elig;
  rq_id_t      sel;
  logic        cmd_valid, sel_wr, sel_rd, accept, push, pop;

  rd_id_fifo #(.DEPTH(MAX_PENDING)) u_rd_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .count   (pending_count)
  );

  // Selection: HOLD pins the owner; ARB prefers the requester not granted last.
  always_comb begin
    elig      = rq_write | (rq_read & {NUM_RQ{~fifo_full}});
    sel       = ~last_q;
    cmd_valid = 1'b0;
    if (state_q == HOLD) begin
      // A held read was admissible when it entered HOLD; count cannot grow
      // while held, so the full check is deliberately skipped here.
      sel       = owner_q;
      cmd_valid = rq_write[owner_q] | rq_read[owner_q];
    end else if (elig[~last_q]) begin
      sel       = ~last_q;
      cmd_valid = 1'b1;
    end else if (elig[last_q]) begin
      sel       = last_q;
      cmd_valid = 1'b1;
    end
  end

  always_comb begin
    sel_wr           = rq_write[sel];
    sel_rd           = rq_read[sel] & ~rq_write[sel];
    master_address   = rq_address[sel];
    master_writedata = rq_writedata[sel];
    master_write     = ~reset & cmd_valid & sel_wr;
    master_read      = ~reset & cmd_valid & sel_rd;
    accept           = ~reset & cmd_valid & ~master_waitrequest;
    push             = accept & sel_rd;
    pop              = ~reset & master_readdatavalid & ~fifo_empty;

    rq_waitrequest = '1;
    if (accept) rq_waitrequest[sel] = 1'b0;

    // Pop routes the pre-push head, so a same-cycle push cannot be returned.
    rq_readdatavalid = '0;
    if (pop) rq_readdatavalid[fifo_head] = 1'b1;
  end

  assign rq_readdata        = master_readdata;
  assign err_unexpected_rdv = err_q;
  assign arb_state          = state_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q | (master_readdatavalid & fifo_empty);
    case (state_q)
      ARB: begin
        if (cmd_valid) begin
          if (master_waitrequest) begin
            state_d = HOLD;
            owner_d = sel;
          end else begin
            last_d = sel;
          end
        end
      end
      HOLD: begin
        if (!master_waitrequest) begin
          state_d = ARB;
          last_d  = owner_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_amm_master_arbiter.sv
// tb_amm_master_arbiter
//   Directed bench for amm_master_arbiter. Stimulus pushes expected accepted
//   commands and expected routed responses into queues; a negedge monitor
//   pops and compares whenever the DUT accepts a command or routes read data.
module tb_amm_master_arbiter;
  import amm_arb_pkg::*;

  localparam int AW   = 28;
  localparam int DW   = 32;
  localparam int MP   = 4;
  localparam int PCW  = $clog2(MP + 1);
  localparam int CMDW = 2 + 1 + 1 + AW + DW;
  localparam int RSPW = 2 + DW;

  logic                     clk;
  logic                     reset;
  logic [1:0][AW-1:0]       rq_address;
  logic [1:0][DW-1:0]       rq_writedata;
  logic [1:0]               rq_read, rq_write;
  logic [1:0]               rq_waitrequest;
  logic [DW-1:0]            rq_readdata;
  logic [1:0]               rq_readdatavalid;
  logic [AW-1:0]            master_address;
  logic [DW-1:0]            master_writedata;
  logic                     master_read, master_write;
  logic [DW-1:0]            master_readdata;
  logic                     master_readdatavalid;
  logic                     master_waitrequest;
  logic [PCW-1:0]           pending_count;
  logic                     err_unexpected_rdv;
  arb_state_t               arb_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CMDW-1:0] exp_cmd_q[$];
  logic [RSPW-1:0] exp_rsp_q[$];

  amm_master_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .MAX_PENDING(MP)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rq_address           (rq_address),
    .rq_writedata         (rq_writedata),
    .rq_read              (rq_read),
    .rq_write             (rq_write),
    .rq_waitrequest       (rq_waitrequest),
    .rq_readdata          (rq_readdata),
    .rq_readdatavalid     (rq_readdatavalid),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .pending_count        (pending_count),
    .err_unexpected_rdv   (err_unexpected_rdv),
    .arb_state            (arb_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CMDW-1:0] cmd(input logic [1:0] gnt, input logic w, input logic r,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {gnt, w, r, a, d};
  endfunction

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq_read              = 2'b00;
    rq_write             = 2'b00;
    master_readdatavalid = 1'b0;
    master_waitrequest   = 1'b0;
  endtask

  task automatic push_rsp(input logic [1:0] rdv, input logic [DW-1:0] d);
    master_readdatavalid = 1'b1;
    master_readdata      = d;
    exp_rsp_q.push_back({rdv, d});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [CMDW-1:0] got_c;
    logic [RSPW-1:0] got_r;
    if (!reset) begin
      if ((master_read || master_write) && !master_waitrequest) begin
        got_c = {~rq_waitrequest, master_write, master_read, master_address, master_writedata};
        if (exp_cmd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cmd_unexpected: got 0x%0h expected none", got_c);
        end else begin
          chk("cmd_accept", 64'(got_c), 64'(exp_cmd_q.pop_front()));
        end
      end
      if (rq_readdatavalid != 2'b00) begin
        got_r = {rq_readdatavalid, rq_readdata};
        if (exp_rsp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got 0x%0h expected none", got_r);
        end else begin
          chk("rsp_route", 64'(got_r), 64'(exp_rsp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    rq_address      = '0;
    rq_writedata    = '0;
    master_readdata = '0;
    idle_inputs();

    // Reset forcing with busy inputs
    rq_read              = 2'b11;
    rq_write             = 2'b10;
    master_readdatavalid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_mread", master_read, 0);
    chk("reset_mwrite", master_write, 0);
    chk("reset_rqwait", rq_waitrequest, 2'b11);
    chk("reset_rdv", rq_readdatavalid, 2'b00);
    cyc();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("reset_pending", pending_count, 0);
    chk("reset_err", err_unexpected_rdv, 0);
    chk("reset_state", arb_state, ARB);

    // Single read
    rq_address[0] = 28'h8000000;
    rq_read       = 2'b01;
    exp_cmd_q.push_back(cmd(2'b01, 1'b0, 1'b1, 28'h8000000, 32'h0));
    #1;
    chk("single_mread", master_read, 1);
    chk("single_rqwait", rq_waitrequest, 2'b10);
    cyc();
    rq_read = 2'b00;
    #1;
    chk("single_mread_off", master_read, 0);
    chk("single_pend1", pending_count, 1);
    cyc();
    push_rsp(2'b01, 32'hCAFE0001);
    #1;
    chk("single_rdv", rq_readdatavalid, 2'b01);
    cyc();
    master_readdatavalid = 1'b0;
    #1;
    chk("single_pend0", pending_count, 0);

    // Contention: reset so requester 0 wins first
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rq_address[0] = 28'h0000100;
    rq_address[1] = 28'h0000200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      rq_read = 2'b11;
      if (i % 2 == 0) exp_cmd_q.push_back(cmd(2'b01, 1'b0, 1'b1, 28'h0000100, 32'h0));
      else            exp_cmd_q.push_back(cmd(2'b10, 1'b0, 1'b1, 28'h0000200, 32'h0));
      #1;
      chk("cont_grant", rq_waitrequest, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    cyc();
    rq_read = 2'b00;
    #1;
    chk("cont_pend4", pending_count, 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      push_rsp((i % 2 == 0) ? 2'b01 : 2'b10, 32'hD0000000 + i);
      #1;
      chk("cont_pend", pending_count, 4 - i);
    end
    cyc();
    master_readdatavalid = 1'b0;
    #1;
    chk("cont_pend0", pending_count, 0);

    // Stall lock: requester 1 write held for 3 stall cycles
    cyc();
    rq_address[1]      = 28'h960D100;
    rq_writedata[1]    = 32'h12;
    rq_write           = 2'b10;
    master_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      if (i == 1) begin
        rq_read       = 2'b01;
        rq_address[0] = 28'h0000300;
      end
      if (i == 3) begin
        master_waitrequest = 1'b0;
        exp_cmd_q.push_back(cmd(2'b10, 1'b1, 1'b0, 28'h960D100, 32'h12));
      end
      #1;
      chk("stall_addr", master_address, 28'h960D100);
      chk("stall_data", master_writedata, 32'h12);
      chk("stall_write", master_write, 1);
      chk("stall_read", master_read, 0);
      chk("stall_rqwait", rq_waitrequest, (i == 3) ? 2'b01 : 2'b11);
    end
    cyc();
    rq_write = 2'b00;
    exp_cmd_q.push_back(cmd(2'b01, 1'b0, 1'b1, 28'h0000300, 32'h0));
    #1;
    chk("stall_next_grant", rq_waitrequest, 2'b10);
    cyc();
    rq_read = 2'b00;
    push_rsp(2'b01, 32'hAAAA0000);
    cyc();
    master_readdatavalid = 1'b0;
    #1;
    chk("stall_pend0", pending_count, 0);

    // FIFO full
    for (int i = 0; i < 4; i++) begin
      cyc();
      rq_read       = 2'b01;
      rq_address[0] = 28'h0000400 + 28'(4 * i);
      exp_cmd_q.push_back(cmd(2'b01, 1'b0, 1'b1, 28'h0000400 + 28'(4 * i), 32'h0));
      #1;
      chk("full_fill_grant", rq_waitrequest, 2'b10);
    end
    cyc();
    rq_address[0]   = 28'h0000410;
    rq_write        = 2'b10;
    rq_address[1]   = 28'h0000500;
    rq_writedata[1] = 32'h55;
    exp_cmd_q.push_back(cmd(2'b10, 1'b1, 1'b0, 28'h0000500, 32'h55));
    #1;
    chk("full_pend4", pending_count, 4);
    chk("full_read_held", master_read, 0);
    chk("full_write_ok", master_write, 1);
    chk("full_rqwait", rq_waitrequest, 2'b01);
    cyc();
    rq_write = 2'b00;
    push_rsp(2'b01, 32'h000000B0);
    #1;
    chk("full_still_held", master_read, 0);
    cyc();
    master_readdatavalid = 1'b0;
    exp_cmd_q.push_back(cmd(2'b01, 1'b0, 1'b1, 28'h0000410, 32'h0));
    #1;
    chk("full_5th_grant", master_read, 1);
    chk("full_5th_rqwait", rq_waitrequest, 2'b10);
    cyc();
    rq_read = 2'b00;
    #1;
    chk("full_pend4b", pending_count, 4);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) cyc();
      push_rsp(2'b01, 32'h000000B1 + i);
    end

    // Simultaneous push and pop at pending_count = 2
    cyc();
    push_rsp(2'b01, 32'h000000B3);
    rq_read       = 2'b10;
    rq_address[1] = 28'h0000600;
    exp_cmd_q.push_back(cmd(2'b10, 1'b0, 1'b1, 28'h0000600, 32'h55));
    #1;
    chk("pp_pend_before", pending_count, 2);
    chk("pp_old_head", rq_readdatavalid, 2'b01);
    chk("pp_mread", master_read, 1);
    cyc();
    rq_read              = 2'b00;
    master_readdatavalid = 1'b0;
    #1;
    chk("pp_pend_after", pending_count, 2);
    cyc();
    push_rsp(2'b01, 32'h000000B4);
    cyc();
    push_rsp(2'b10, 32'h000000B5);
    cyc();
    master_readdatavalid = 1'b0;
    #1;
    chk("pp_pend0", pending_count, 0);

    // Unexpected readdatavalid
    cyc();
    master_readdatavalid = 1'b1;
    master_readdata      = 32'h000000EE;
    #1;
    chk("err_no_route", rq_readdatavalid, 2'b00);
    chk("err_not_yet", err_unexpected_rdv, 0);
    cyc();
    master_readdatavalid = 1'b0;
    #1;
    chk("err_set", err_unexpected_rdv, 1);
    cyc();
    #1;
    chk("err_sticky", err_unexpected_rdv, 1);

    // Reset during HOLD with a read outstanding
    cyc();
    rq_read       = 2'b01;
    rq_address[0] = 28'h0000700;
    exp_cmd_q.push_back(cmd(2'b01, 1'b0, 1'b1, 28'h0000700, 32'h0));
    cyc();
    rq_read            = 2'b00;
    rq_write           = 2'b01;
    rq_writedata[0]    = 32'h77;
    master_waitrequest = 1'b1;
    #1;
    chk("rst_pend1", pending_count, 1);
    cyc();
    #1;
    chk("rst_in_hold", arb_state, HOLD);
    chk("rst_hold_write", master_write, 1);
    cyc();
    reset = 1'b1;
    #1;
    chk("rst_mwrite", master_write, 0);
    chk("rst_mread", master_read, 0);
    chk("rst_rqwait", rq_waitrequest, 2'b11);
    cyc();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_err_clr", err_unexpected_rdv, 0);
    chk("rst_state", arb_state, ARB);
    chk("rst_pend0", pending_count, 0);
    cyc();
    master_readdatavalid = 1'b1;
    master_readdata      = 32'h00000099;
    #1;
    chk("rst_late_rdv", rq_readdatavalid, 2'b00);
    cyc();
    master_readdatavalid = 1'b0;
    #1;
    chk("rst_late_err", err_unexpected_rdv, 1);

    // Final report
    cyc();
    cyc();
    chk("cmd_queue_empty", exp_cmd_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/amm_master_arbiter.md
# amm_master_arbiter

Two-requester Avalon-MM arbiter that shares the single SDRAM master port between the PCA projection engine (requester 0) and the face-distance/classification engine (requester 1). It grants commands round-robin and holds the grant while the slave stalls. It tracks outstanding pipelined reads in an ID FIFO so that each `readdatavalid` returns to the requester that issued the read.

## Interface
- `ADDRESSWIDTH`, 28: master/requester address width.
- `DATAWIDTH`, 32: data width.
- `MAX_PENDING`, 4: maximum number of outstanding reads (ID FIFO depth); must be ≥1.
- `clk` in 1: single clock.
- `reset` in 1: reset, synchronous and active-high (fixed).
- `rq_address` in [1:0][ADDRESSWIDTH-1:0]: per-requester address.
- `rq_writedata` in [1:0][DATAWIDTH-1:0]: per-requester write data.
- `rq_read`, `rq_write` in [1:0]: per-requester command strobes.
- `rq_waitrequest` out [1:0]: low only in the cycle the requester's command is accepted by the slave.
- `rq_readdata` out [DATAWIDTH-1:0]: `master_readdata`, broadcast to both requesters.
- `rq_readdatavalid` out [1:0]: one-hot routed read-data-valid.
- `master_address` out [ADDRESSWIDTH-1:0], `master_writedata` out [DATAWIDTH-1:0], `master_read` out 1, `master_write` out 1: master command.
- `master_readdata` in [DATAWIDTH-1:0], `master_readdatavalid` in 1, `master_waitrequest` in 1: master response.
- `pending_count` out [$clog2(MAX_PENDING+1)-1:0]: number of outstanding reads.
- `err_unexpected_rdv` out 1: sticky; set by a `readdatavalid` arriving while no read is outstanding.

## Operation
- **Eligibility.** Requester i is eligible when `rq_write[i]` is set, or when `rq_read[i]` is set and the FIFO is not full.
  - If `rq_read` and `rq_write` are both set, the command is treated as a write and the read is ignored.
- **FSM states:** ARB, HOLD.
- **ARB:**
  - If no requester is eligible, all master strobes are 0.
  - Otherwise select the eligible requester with priority to `~last_grant`, and forward its address, data and strobe combinationally.
  - If `master_waitrequest`=0: the command is accepted. Drive `rq_waitrequest[sel]`=0, set `last_grant`←sel, stay in ARB.
  - If `master_waitrequest`=1: set `owner`←sel and go to HOLD.
- **HOLD:**
  - Forward `owner`'s command regardless of the other requester. Arbitration is frozen, because the Avalon command must stay stable while `waitrequest` is high.
  - On `master_waitrequest`=0: accept, set `last_grant`←owner, go to ARB.
  - A read held in HOLD is already counted as admissible; the full check is not re-evaluated.
- **FIFO push.** A read accepted in a given cycle pushes the requester's ID.
- **FIFO pop.** `master_readdatavalid`=1 pops the head ID and drives `rq_readdatavalid[head]`=1 in the same cycle.
  - On an empty FIFO, nothing is routed and `err_unexpected_rdv`←1.
  - A push and a pop in the same cycle leave `pending_count` unchanged; the pop uses the pre-push head.
- **Writes** never touch the FIFO and may be accepted while the FIFO is full.
- `rq_waitrequest[i]`=1 for a non-selected requester and while `master_waitrequest`=1.

## Timing
- Zero-cycle combinational paths:
  - requester → master command;
  - `master_waitrequest` → `rq_waitrequest`;
  - `master_readdatavalid` → `rq_readdatavalid`.
- Registered state: FSM state, `owner`, `last_grant`, FIFO, `pending_count`, `err_unexpected_rdv`.
- Reset values: state=ARB, `last_grant`=1 (so requester 0 wins first), FIFO empty, `pending_count`=0, `err_unexpected_rdv`=0.
- While `reset`=1, the following are forced:
  - `master_read`=`master_write`=0;
  - `rq_waitrequest`=2'b11;
  - `rq_readdatavalid`=0.
- Reset mid-transaction discards HOLD and all pending IDs; responses arriving after reset set the error flag.
- Back-to-back acceptance alternates requesters every cycle when both are continuously eligible.
- `pending_count` never exceeds `MAX_PENDING`.

## Structure
- Package `amm_arb_pkg` contains:
  - `typedef enum {ARB, HOLD} arb_state_t`;
  - `typedef logic rq_id_t`;
  - `localparam NUM_RQ = 2`.
- Sub-module `rd_id_fifo`:
  - synchronous FIFO, width `rq_id_t`, depth `MAX_PENDING`;
  - outputs `full`, `empty`, `head`, `count`;
  - pointers wrap modulo the depth.
- The arbiter top holds the FSM, round-robin selection and muxing.

## Test plan
- **Single read.** Only requester 0 reads 0x08000000; slave has `waitrequest`=0 and returns 0xCAFE0001 two cycles later.
  - Required: `master_read` for 1 cycle, `pending_count` 0→1→0, `rq_readdatavalid`=2'b01 with `rq_readdata`=0xCAFE0001.
- **Contention.** Both requesters hold reads continuously.
  - Required: grants in order 0,1,0,1; response IDs return in the same order; `rq_readdatavalid` is one-hot.
- **Stall lock.** `master_waitrequest`=1 for 3 cycles while requester 1 writes 0x12 to 0x0960D100 and requester 0 raises a read.
  - Required: address, data and strobe are stable for 4 cycles; requester 0 is granted in the cycle after acceptance.
- **FIFO full.** Requester 0 issues 4 reads with no responses, then a 5th.
  - Required: the 5th is held (`rq_waitrequest[0]`=1, `master_read`=0).
  - Required: a concurrent requester-1 write is accepted.
  - Required: after one `readdatavalid`, the 5th read is granted.
- **Simultaneous push and pop.** A read is accepted in the same cycle as a `readdatavalid` with `pending_count`=2.
  - Required: `pending_count` stays 2 and the old head ID is routed.
- **Error and reset.** `readdatavalid` arrives with the FIFO empty.
  - Required: `err_unexpected_rdv`=1 and stays set; `rq_readdatavalid`=0.
  - Required: `reset` pulsed during HOLD clears the flag and FSM state, and forces the master strobes to 0.
